// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake bundle for fifo_wr_arbiter.
// Requesters drive valid/last/data through the master modport; the arbiter
// answers with one combinational ready bit per requester through the slave modport.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one fifo_sync among NUM_REQ requesters.
// Multi-beat packets stay contiguous, and a local credit counter mirrors free
// FIFO space so a write is never issued to a full FIFO.
//
// state | meaning
// IDLE  | no packet open; round-robin search from rr_ptr+1 picks the winner
// LOCK  | packet open for grant_id; only that requester may be accepted
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_wr_arbiter_if.slave      req_if,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_pop,
    output logic [ADDR_WIDTH:0]   credits,
    output logic [GW-1:0]         grant_id,
    output logic                  locked,
    output logic                  credit_err
);
    localparam logic [ADDR_WIDTH:0] CRED_MAX = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH:0]   credits_q, credits_d;
    logic                  credit_err_q;

    logic [GW-1:0]         winner;
    logic                  win_found;
    logic [GW-1:0]         sel;
    logic                  sel_ok;
    logic                  xfer;
    logic                  sel_last;
    logic                  pop_overflow;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign data_arr[i] = req_if.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first valid requester after rr_ptr, wrapping.
    always_comb begin
        int            idx_i;
        logic [GW-1:0] idx_g;
        win_found = 1'b0;
        winner    = '0;
        idx_i     = 0;
        idx_g     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_i = (int'(rr_ptr_q) + k) % NUM_REQ;
            idx_g = GW'(idx_i);
            if (!win_found && req_if.req_valid[idx_g]) begin
                win_found = 1'b1;
                winner    = idx_g;
            end
        end
    end

    // Ready generation, packet FSM and credit arithmetic.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_d          = grant_q;
        credits_d        = credits_q;
        req_if.req_ready = '0;

        sel    = (state_q == LOCK) ? grant_q : winner;
        sel_ok = (state_q == LOCK) || win_found;
        // Ready only looks at registered credits, never at fifo_pop.
        if (sel_ok && (credits_q != '0))
            req_if.req_ready[sel] = 1'b1;

        xfer     = req_if.req_valid[sel] && req_if.req_ready[sel];
        sel_last = req_if.req_last[sel];
        sel_data = data_arr[sel];

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    grant_d = sel;
                    if (sel_last)
                        rr_ptr_d = sel;
                    else
                        state_d = LOCK;
                end
            end
            LOCK: begin
                if (xfer && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop with the counter already at full capacity is bogus: drop it.
        pop_overflow = fifo_pop && (credits_q == CRED_MAX);
        if (pop_overflow)
            credits_d = credits_q - (ADDR_WIDTH+1)'(xfer);
        else
            credits_d = credits_q - (ADDR_WIDTH+1)'(xfer) + (ADDR_WIDTH+1)'(fifo_pop);
    end

    // Control registers; rr_ptr starts at the top so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            credits_q    <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_q | pop_overflow;
        end
    end

    // Registered write strobe and data straight to the FIFO; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else begin
            fifo_wr_en <= xfer;
            if (xfer)
                fifo_din <= sel_data;
        end
    end

    assign credits    = credits_q;
    assign grant_id   = grant_q;
    assign locked     = (state_q == LOCK);
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, ADDR_WIDTH=3).
// Accepted beats are queued when driven and compared when fifo_wr_en fires.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_pop = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic [AW:0]   credits;
    logic [1:0]    grant_id;
    logic          locked;
    logic          credit_err;

    logic [DW-1:0] dat [NR];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            failures = 0;
    int            occ = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) rif ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (rif),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_pop   (fifo_pop),
        .credits    (credits),
        .grant_id   (grant_id),
        .locked     (locked),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Independent FIFO occupancy model: writes land one edge after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= 0;
        else        occ <= occ + int'(fifo_wr_en) - int'(fifo_pop);
    end

    // Scoreboard: every FIFO write must match the oldest expected beat.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) check("sb_unexpected_write", 32'(fifo_din), 32'hFFFF_FFFF);
            else                   check("sb_din", 32'(fifo_din), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [3:0] exp_rdy,
                        input logic exp_lock, input logic exp_wr, input string tag);
        rif.req_valid = v;
        rif.req_last  = l;
        rif.req_data  = {dat[3], dat[2], dat[1], dat[0]};
        @(negedge clk);
        check({tag, "_rdy"},  32'(rif.req_ready), 32'(exp_rdy));
        check({tag, "_lock"}, 32'(locked), 32'(exp_lock));
        check({tag, "_wr"},   32'(fifo_wr_en), 32'(exp_wr));
        for (int i = 0; i < NR; i++)
            if (v[i] && exp_rdy[i]) exp_q.push_back(dat[i]);
        tick();
    endtask

    initial begin
        rif.req_valid = '0;
        rif.req_last  = '0;
        rif.req_data  = '0;
        for (int i = 0; i < NR; i++) dat[i] = '0;

        // reset values
        #12;
        check("rst_credits", 32'(credits), 32'd8);
        check("rst_wr_en",   32'(fifo_wr_en), 32'd0);
        check("rst_din",     32'(fifo_din), 32'd0);
        check("rst_grant",   32'(grant_id), 32'd0);
        check("rst_locked",  32'(locked), 32'd0);
        check("rst_err",     32'(credit_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // all requesters valid, single-beat: grants 0,1,2,3,0
        for (int i = 0; i < NR; i++) dat[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 4'hF, 4'(1 << (i % 4)), 1'b0, (i > 0), "t1");
            check("t1_grant", 32'(grant_id), 32'(i % 4));
        end
        step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, "t1_tail");
        check("t1_credits", 32'(credits), 32'd3);
        check("t1_occ", 32'(credits), 32'(8 - occ - int'(fifo_wr_en)));
        fifo_pop = 1'b1;
        repeat (5) tick();
        fifo_pop = 1'b0;
        check("t1_refill", 32'(credits), 32'd8);

        // packet lock with a valid gap while requester 1 waits
        dat[1] = 8'hC1;
        step(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, "t2_pre");
        dat[1] = 8'hC2;
        dat[2] = 8'hB0;
        step(4'b0110, 4'b0010, 4'b0100, 1'b0, 1'b1, "t2_b0");
        step(4'b0010, 4'b0010, 4'b0100, 1'b1, 1'b1, "t2_gap");
        check("t2_grant", 32'(grant_id), 32'd2);
        dat[2] = 8'hB1;
        step(4'b0110, 4'b0010, 4'b0100, 1'b1, 1'b0, "t2_b1");
        dat[2] = 8'hB2;
        step(4'b0110, 4'b0110, 4'b0100, 1'b1, 1'b1, "t2_b2");
        dat[3] = 8'hD3;
        dat[0] = 8'hD0;
        step(4'b1011, 4'b1011, 4'b1000, 1'b0, 1'b1, "t2_g3");
        step(4'b0011, 4'b0011, 4'b0001, 1'b0, 1'b1, "t2_g0");
        step(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b1, "t2_g1");
        check("t2_grant_last", 32'(grant_id), 32'd1);
        rif.req_valid = '0;
        tick();
        check("t2_credits", 32'(credits), 32'd1);
        fifo_pop = 1'b1;
        repeat (7) tick();
        fifo_pop = 1'b0;
        check("t2_refill", 32'(credits), 32'd8);

        // credit exhaustion: exactly 8 beats, then a pop frees exactly one more
        for (int k = 0; k < 8; k++) begin
            dat[0] = 8'h10 + 8'(k);
            step(4'b0001, 4'b0001, 4'b0001, 1'b0, (k > 0), "t3_acc");
        end
        check("t3_empty_credits", 32'(credits), 32'd0);
        step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, "t3_full");
        fifo_pop = 1'b1;
        step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "t3_pop_same");
        fifo_pop = 1'b0;
        check("t3_after_pop", 32'(credits), 32'd1);
        dat[0] = 8'h18;
        step(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, "t3_one");
        check("t3_zero_again", 32'(credits), 32'd0);
        step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, "t3_full2");

        // simultaneous xfer and pop at credits=1
        fifo_pop = 1'b1;
        step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "t4_pop");
        check("t4_credits1", 32'(credits), 32'd1);
        dat[0] = 8'h19;
        step(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, "t4_xp");
        fifo_pop = 1'b0;
        check("t4_hold", 32'(credits), 32'd1);
        check("t4_occ", 32'(credits), 32'(8 - occ - int'(fifo_wr_en)));
        rif.req_valid = '0;
        fifo_pop = 1'b1;
        repeat (7) tick();
        fifo_pop = 1'b0;
        check("t4_refill", 32'(credits), 32'd8);
        check("t4_occ_zero", 32'(occ), 32'd0);

        // pop at full credits is an error and is sticky
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        check("t5_credits", 32'(credits), 32'd8);
        check("t5_err", 32'(credit_err), 32'd1);
        repeat (3) tick();
        check("t5_err_sticky", 32'(credit_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_err_clear", 32'(credit_err), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();

        // asynchronous reset in the middle of a 4-beat packet
        dat[2] = 8'hE0;
        step(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, "t6_b1");
        dat[2] = 8'hE1;
        rif.req_data = {dat[3], dat[2], dat[1], dat[0]};
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_locked", 32'(locked), 32'd0);
        check("t6_grant",  32'(grant_id), 32'd0);
        check("t6_credits", 32'(credits), 32'd8);
        check("t6_wr_en",  32'(fifo_wr_en), 32'd0);
        check("t6_din",    32'(fifo_din), 32'd0);
        rif.req_valid = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        dat[0] = 8'hF0;
        dat[2] = 8'hF2;
        step(4'b0101, 4'b0101, 4'b0001, 1'b0, 1'b0, "t6_first");
        step(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b1, "t6_second");
        rif.req_valid = '0;
        tick();
        tick();
        check("t6_credits_end", 32'(credits), 32'd6);

        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `fifo_sync` instance among NUM_REQ requesters using valid/ready/last. It grants one requester at a time and keeps multi-beat packets contiguous. It tracks FIFO occupancy with its own credit counter, so it never issues a write to a full FIFO. Write strobes are registered and drive the FIFO `wr_en`/`din` directly.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- DATA_WIDTH, 8: beat width; must equal the FIFO DATA_WIDTH
- ADDR_WIDTH, 5: FIFO ADDR_WIDTH; FIFO depth is 2^ADDR_WIDTH
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset; the FIFO must be reset by the same rst_n
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept, combinational
- fifo_wr_en  out  1  registered write strobe to FIFO wr_en
- fifo_din  out  DATA_WIDTH  registered write data to FIFO din
- fifo_pop  in  1  one pulse per entry removed from the FIFO (consumer rd_en && ~empty)
- credits  out  ADDR_WIDTH+1  free FIFO entries as seen by the arbiter
- grant_id  out  log2(NUM_REQ) (min 1)  current or last granted requester
- locked  out  1  a packet is in progress
- credit_err  out  1  sticky; fifo_pop arrived while credits == 2^ADDR_WIDTH

## Operation
- **State machine**
  - States are IDLE and LOCK.
  - Registers: rr_ptr, grant_id, credits.
- **IDLE arbitration**
  - Pick the first i with req_valid[i] set, searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[i] = 1 only for the winner, and only if credits != 0. All other ready bits are 0.
- **Transfer**
  - A transfer (xfer) is req_valid[i] && req_ready[i].
  - On xfer with req_last[i]=1: stay in IDLE; rr_ptr <= i; grant_id <= i.
  - On xfer with req_last[i]=0: go to LOCK; grant_id <= i.
- **LOCK**
  - Only req_ready[grant_id] can be asserted, gated by credits != 0.
  - Other requesters are ignored even if valid.
  - On xfer with last=1: go to IDLE; rr_ptr <= grant_id.
  - A gap in req_valid inside a packet keeps LOCK.
- **Credits**
  - Next value: credits_next = credits - xfer + fifo_pop, computed at ADDR_WIDTH+1 bits.
  - Simultaneous xfer and pop leaves credits unchanged.
  - A pop in cycle n raises ready no earlier than cycle n+1; there is no same-cycle bypass.
  - Pop while credits == 2^ADDR_WIDTH: credits holds, and credit_err sets until reset.
- **Write path**
  - fifo_wr_en <= xfer.
  - fifo_din <= req_data of the accepted requester when xfer=1; otherwise fifo_din holds.
- **Reset values**
  - State IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - grant_id = 0, locked = 0, credits = 2^ADDR_WIDTH.
  - fifo_wr_en = 0, fifo_din = 0, credit_err = 0.
  - Reset mid-packet drops the packet.
  - Requesters must re-send the whole packet; the FIFO is emptied by the same reset.

## Timing
- Latency: an accepted beat appears as fifo_wr_en=1 on the next rising edge. There is one beat in flight, at most.
- Throughput: one beat per cycle while credits > 0.
  - Back-to-back single-beat packets from different requesters sustain one beat per cycle.
  - There is no idle cycle on IDLE→LOCK or LOCK→IDLE.
- req_ready combinational paths:
  - From req_valid of all requesters, in IDLE.
  - From state, credits and grant_id registers.
  - No path from fifo_pop.
- Requesters must hold req_valid, req_data and req_last stable until ready.
- Credits are decremented at xfer, one cycle before the FIFO sees the write, so the arbiter can never overflow the FIFO.
- Credits stay conservative for pops: the FIFO's internal count lags, and credits may read lower than true space, never higher.
- credits never goes below 0 or above 2^ADDR_WIDTH.

## Test plan
- **Reset default:** all requesters valid, single-beat. Grants go 0,1,2,3,0. fifo_wr_en is high every cycle from cycle 1. fifo_din follows the pattern 0xA0..0xA3.
- **Packet lock:** requester 2 sends a 3-beat packet with a 1-cycle valid gap while requester 1 is valid. Requester 1 gets no ready until the cycle after requester 2's last beat; locked drops then; next grant is 3→0→1 order from rr_ptr=2.
- **Credit exhaustion:** ADDR_WIDTH=3, no pops. Exactly 8 beats are accepted, credits reaches 0, and all req_ready are 0. One fifo_pop gives credits=1 the next cycle and exactly one more beat is accepted.
- **Simultaneous xfer and pop at credits=1:** credits stays 1 and the FIFO count matches the arbiter count in the scoreboard.
- **Credit error:** fifo_pop pulsed at credits=8, ADDR_WIDTH=3. credits stays 8 and credit_err=1 until rst_n is asserted.
- **Reset mid-packet:** rst_n pulsed low during beat 2 of 4. All outputs return to reset values immediately (asynchronous). After release, requester 0 wins first and credits=2^ADDR_WIDTH.
